// File: rtl/decode_writeback_if.sv
// Handshake bundle between fetch/execute and the decode/write-back stage.
interface decode_writeback_if #(
  parameter int DATA_W = 64
);
  logic              d_valid;
  logic [3:0]        d_icode;
  logic [3:0]        d_rA;
  logic [3:0]        d_rB;
  logic [3:0]        d_srcA;
  logic [3:0]        d_srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic              d_done;
  logic              d_err;
  logic              w_valid;
  logic [3:0]        w_icode;
  logic [3:0]        w_rA;
  logic [3:0]        w_rB;
  logic              w_cnd;
  logic [DATA_W-1:0] w_valE;
  logic [DATA_W-1:0] w_valM;
  logic [3:0]        w_dstE;
  logic [3:0]        w_dstM;
  logic              w_done;
  logic [3:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output d_valid, d_icode, d_rA, d_rB,
    output w_valid, w_icode, w_rA, w_rB,
    output w_cnd, w_valE, w_valM, dbg_sel,
    input  d_srcA, d_srcB, valA, valB,
    input  d_done, d_err,
    input  w_dstE, w_dstM, w_done, dbg_data
  );

  modport slave (
    input  d_valid, d_icode, d_rA, d_rB,
    input  w_valid, w_icode, w_rA, w_rB,
    input  w_cnd, w_valE, w_valM, dbg_sel,
    output d_srcA, d_srcB, valA, valB,
    output d_done, d_err,
    output w_dstE, w_dstM, w_done, dbg_data
  );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode / write-back stage with the shared register file.
// Decode reads through a same-cycle write bypass (valM over valE).
module decode_writeback #(
  parameter int DATA_W  = 64,
  parameter int NREG    = 15,
  parameter int RSP_IDX = 4
) (
  input logic             clk,
  input logic             rst,
  decode_writeback_if.slave bus
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = RSP_IDX[3:0];

  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        src_a, src_b;
  logic [3:0]        dst_e, dst_m;
  logic              w_ok;
  logic [DATA_W-1:0] rd_a, rd_b;

  always_comb begin
    src_a = RNONE;
    unique case (1'b1)
      bus.d_icode inside {4'h2, 4'h4, 4'h6, 4'hA}:
        src_a = bus.d_rA;
      bus.d_icode inside {4'h9, 4'hB}:
        src_a = RSP;
      default: ;
    endcase
  end

  always_comb begin
    src_b = RNONE;
    unique case (1'b1)
      bus.d_icode inside {4'h4, 4'h5, 4'h6}:
        src_b = bus.d_rB;
      bus.d_icode inside {4'h8, 4'h9, 4'hA, 4'hB}:
        src_b = RSP;
      default: ;
    endcase
  end

  always_comb begin
    dst_e = RNONE;
    unique case (1'b1)
      bus.w_icode inside {4'h3, 4'h6}:
        dst_e = bus.w_rB;
      bus.w_icode == 4'h2:
        dst_e = bus.w_cnd ? bus.w_rB : RNONE;
      bus.w_icode inside {4'h8, 4'h9, 4'hA, 4'hB}:
        dst_e = RSP;
      default: ;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    unique case (1'b1)
      bus.w_icode inside {4'h5, 4'hB}:
        dst_m = bus.w_rA;
      default: ;
    endcase
  end

  assign w_ok = bus.w_valid && (bus.w_icode <= 4'hB);

  // Bypass mirrors the commit priority: valM shadows valE.
  always_comb begin
    rd_a = '0;
    if (src_a != RNONE) begin
      if (w_ok && src_a == dst_m)
        rd_a = bus.w_valM;
      else if (w_ok && src_a == dst_e)
        rd_a = bus.w_valE;
      else
        rd_a = regs[src_a];
    end
  end

  always_comb begin
    rd_b = '0;
    if (src_b != RNONE) begin
      if (w_ok && src_b == dst_m)
        rd_b = bus.w_valM;
      else if (w_ok && src_b == dst_e)
        rd_b = bus.w_valE;
      else
        rd_b = regs[src_b];
    end
  end

  assign bus.dbg_data = (bus.dbg_sel == RNONE)
                      ? '0 : regs[bus.dbg_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      bus.d_srcA  <= RNONE;
      bus.d_srcB  <= RNONE;
      bus.valA    <= '0;
      bus.valB    <= '0;
      bus.d_done  <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.w_dstE  <= RNONE;
      bus.w_dstM  <= RNONE;
      bus.w_done  <= 1'b0;
    end else begin
      bus.d_done <= bus.d_valid;
      bus.w_done <= bus.w_valid;
      if (bus.d_valid) begin
        bus.d_srcA <= src_a;
        bus.d_srcB <= src_b;
        bus.valA   <= rd_a;
        bus.valB   <= rd_b;
        bus.d_err  <= (bus.d_icode > 4'hB);
      end
      if (bus.w_valid) begin
        bus.w_dstE <= dst_e;
        bus.w_dstM <= dst_m;
      end
      if (w_ok && dst_e != RNONE)
        regs[dst_e] <= bus.w_valE;
      if (w_ok && dst_m != RNONE)
        regs[dst_m] <= bus.w_valM;
    end
  end
endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback.
// Drives on the falling edge, checks after it.
module tb_decode_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  decode_writeback_if #(.DATA_W(64)) bus ();

  decode_writeback #(
    .DATA_W(64), .NREG(15), .RSP_IDX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [3:0] ic,
                       input logic [3:0] ra,
                       input logic [3:0] rb);
    bus.d_valid = 1'b1;
    bus.d_icode = ic;
    bus.d_rA    = ra;
    bus.d_rB    = rb;
  endtask

  task automatic set_w(input logic [3:0] ic,
                       input logic [3:0] ra,
                       input logic [3:0] rb,
                       input logic       cnd,
                       input logic [63:0] e,
                       input logic [63:0] m);
    bus.w_valid = 1'b1;
    bus.w_icode = ic;
    bus.w_rA    = ra;
    bus.w_rB    = rb;
    bus.w_cnd   = cnd;
    bus.w_valE  = e;
    bus.w_valM  = m;
  endtask

  task automatic step;
    @(negedge clk);
    bus.d_valid = 1'b0;
    bus.w_valid = 1'b0;
  endtask

  task automatic dbg(input logic [3:0] sel,
                     input logic [63:0] exp,
                     input string tag);
    bus.dbg_sel = sel;
    #1;
    chk(tag, bus.dbg_data, exp);
  endtask

  initial begin
    logic [63:0] acc;
    bus.d_valid = 0; bus.d_icode = 0;
    bus.d_rA = 0; bus.d_rB = 0;
    bus.w_valid = 0; bus.w_icode = 0;
    bus.w_rA = 0; bus.w_rB = 0; bus.w_cnd = 0;
    bus.w_valE = 0; bus.w_valM = 0;
    bus.dbg_sel = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_srcA", 64'(bus.d_srcA), 64'hF);
    chk("rst_srcB", 64'(bus.d_srcB), 64'hF);
    chk("rst_done", 64'(bus.d_done), 64'h0);
    chk("rst_dstE", 64'(bus.w_dstE), 64'hF);
    chk("rst_dstM", 64'(bus.w_dstM), 64'hF);
    chk("rst_wdone", 64'(bus.w_done), 64'h0);
    dbg(4'd2, 64'h0, "rst_r2");

    set_d(4'h6, 4'd2, 4'd3); step();
    chk("d1_done", 64'(bus.d_done), 64'h1);
    chk("d1_srcA", 64'(bus.d_srcA), 64'h2);
    chk("d1_srcB", 64'(bus.d_srcB), 64'h3);
    chk("d1_valA", bus.valA, 64'h0);
    chk("d1_valB", bus.valB, 64'h0);

    set_w(4'h3, 4'hF, 4'd2, 0, 64'hAB, 64'h0);
    step();
    chk("d1_done_drop", 64'(bus.d_done), 64'h0);
    chk("irm_wdone", 64'(bus.w_done), 64'h1);
    chk("irm_dstE", 64'(bus.w_dstE), 64'h2);
    chk("irm_dstM", 64'(bus.w_dstM), 64'hF);
    set_d(4'h6, 4'd2, 4'd3); step();
    chk("irm_wdone_drop", 64'(bus.w_done), 64'h0);
    chk("irm_valA", bus.valA, 64'hAB);
    chk("irm_valB", bus.valB, 64'h0);

    set_w(4'h3, 4'hF, 4'd4, 0, 64'h100, 64'h0);
    step();
    dbg(4'd4, 64'h100, "rsp_set");
    set_w(4'hB, 4'd4, 4'hF, 0, 64'h108, 64'h55);
    step();
    dbg(4'd4, 64'h55, "pop_valM_wins");
    chk("pop_dstE", 64'(bus.w_dstE), 64'h4);
    chk("pop_dstM", 64'(bus.w_dstM), 64'h4);

    set_w(4'h2, 4'hF, 4'd5, 0, 64'h77, 64'h0);
    step();
    chk("cmov0_dstE", 64'(bus.w_dstE), 64'hF);
    dbg(4'd5, 64'h0, "cmov0_r5");
    set_w(4'h2, 4'hF, 4'd5, 1, 64'h77, 64'h0);
    step();
    chk("cmov1_dstE", 64'(bus.w_dstE), 64'h5);
    dbg(4'd5, 64'h77, "cmov1_r5");

    set_w(4'h3, 4'hF, 4'd1, 0, 64'h9, 64'h0);
    set_d(4'h2, 4'd1, 4'hF);
    step();
    chk("byp_valA", bus.valA, 64'h9);
    chk("byp_srcA", 64'(bus.d_srcA), 64'h1);
    chk("byp_srcB", 64'(bus.d_srcB), 64'hF);
    dbg(4'd1, 64'h9, "byp_r1");

    set_w(4'hB, 4'd4, 4'hF, 0, 64'h200, 64'h300);
    set_d(4'hA, 4'd5, 4'hF);
    step();
    chk("bypM_valA", bus.valA, 64'h77);
    chk("bypM_valB", bus.valB, 64'h300);
    dbg(4'd4, 64'h300, "bypM_r4");

    set_d(4'hC, 4'd2, 4'd5); step();
    chk("ill_done", 64'(bus.d_done), 64'h1);
    chk("ill_err", 64'(bus.d_err), 64'h1);
    chk("ill_valA", bus.valA, 64'h0);
    chk("ill_valB", bus.valB, 64'h0);
    chk("ill_srcA", 64'(bus.d_srcA), 64'hF);
    step();
    chk("ill_done_drop", 64'(bus.d_done), 64'h0);
    chk("ill_err_hold", 64'(bus.d_err), 64'h1);

    set_d(4'h6, 4'd1, 4'd2);
    @(negedge clk);
    chk("b2b1_done", 64'(bus.d_done), 64'h1);
    chk("b2b1_err", 64'(bus.d_err), 64'h0);
    chk("b2b1_valA", bus.valA, 64'h9);
    chk("b2b1_valB", bus.valB, 64'hAB);
    set_d(4'h6, 4'd2, 4'd5); step();
    chk("b2b2_done", 64'(bus.d_done), 64'h1);
    chk("b2b2_valA", bus.valA, 64'hAB);
    chk("b2b2_valB", bus.valB, 64'h77);

    set_w(4'hC, 4'hF, 4'd1, 0, 64'hFF, 64'hEE);
    step();
    chk("illw_done", 64'(bus.w_done), 64'h1);
    chk("illw_dstE", 64'(bus.w_dstE), 64'hF);
    dbg(4'd1, 64'h9, "illw_r1");

    set_d(4'h6, 4'd1, 4'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstp_done", 64'(bus.d_done), 64'h0);
    chk("rstp_valA", bus.valA, 64'h0);
    step();
    chk("rstp_done2", 64'(bus.d_done), 64'h0);
    acc = '0;
    for (int i = 0; i < 15; i++) begin
      bus.dbg_sel = 4'(i);
      #1;
      acc = acc | bus.dbg_data;
    end
    chk("rstp_regs_or", acc, 64'h0);
    dbg(4'd4, 64'h0, "rstp_r4");
    dbg(4'hF, 64'h0, "dbg_rnone");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
